sls_serial_adder_v: RTL and testbench

Parametrised bit-serial adder/subtractor built around a single full-adder cell and a carry flip-flop. It generalises the combinational full adder to WIDTH-bit operands by processing one bit per clock, LSB first. It adds a subtract mode, signed-overflow detection and a start/busy/done handshake. It sits beside the lab's combinational adders as the first sequential datapath block and is reused by later multi-cycle arithmetic units.

---
 rtl/sls_serial_adder_v.sv | 104 ++++++++++
 tb/tb_sls_serial_adder_v.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/sls_serial_adder_v.sv
// Bit-serial adder/subtractor: one full-adder cell plus a carry flop, LSB first.
// Subtraction uses a + ~b + 1. Results are registered and held until the next completion.
module sls_serial_adder_v #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic w_s;
  logic w_c;
  logic w_last;

  assign w_s    = r_a[0] ^ r_b[0] ^ r_carry;
  assign w_c    = (r_a[0] & r_b[0]) | (r_carry & (r_a[0] ^ r_b[0]));
  assign w_last = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub ? 1'b1 : cin;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_res   <= {w_s, r_res[WIDTH-1:1]};
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_carry <= w_c;
          r_cnt   <= r_cnt + CW'(1);
          // r_carry here is the carry into the MSB, so overflow is formed directly.
          if (w_last) begin
            r_sum   <= {w_s, r_res[WIDTH-1:1]};
            r_cout  <= w_c;
            r_ovf   <= r_carry ^ w_c;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign sum      = r_sum;
  assign cout     = r_cout;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_sls_serial_adder_v.sv
// Directed bench for sls_serial_adder_v: WIDTH=8 vectors, handshake and reset cases,
// plus an exhaustive WIDTH=4 sweep against a behavioural model.
module tb_sls_serial_adder_v;

  logic clk;
  logic rst_n;

  logic       s8_start, s8_sub, s8_cin;
  logic [7:0] s8_a, s8_b;
  logic       o8_busy, o8_done, o8_cout, o8_ovf;
  logic [7:0] o8_sum;

  logic       s4_start, s4_sub, s4_cin;
  logic [3:0] s4_a, s4_b;
  logic       o4_busy, o4_done, o4_cout, o4_ovf;
  logic [3:0] o4_sum;

  int unsigned checks;
  int unsigned failures;
  logic        last_ok;

  sls_serial_adder_v #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(s8_start), .sub(s8_sub), .cin(s8_cin),
    .a(s8_a), .b(s8_b), .busy(o8_busy), .done(o8_done), .sum(o8_sum),
    .cout(o8_cout), .overflow(o8_ovf)
  );

  sls_serial_adder_v #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(s4_start), .sub(s4_sub), .cin(s4_cin),
    .a(s4_a), .b(s4_b), .busy(o4_busy), .done(o4_done), .sum(o4_sum),
    .cout(o4_cout), .overflow(o4_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    last_ok = 1'b1;
    assert (obs === exp) else begin
      failures++;
      last_ok = 1'b0;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the 8-bit DUT idle; returns at the negedge where done is seen.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic sub,
                      input logic cin, output int unsigned lat);
    s8_a = a; s8_b = b; s8_sub = sub; s8_cin = cin; s8_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s8_start = 1'b0;
    s8_a = 8'hxx; s8_b = 8'hxx;
    lat = 0;
    while (!o8_done && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic vec8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic sub, input logic cin, input logic [7:0] esum,
                      input logic ecout, input logic eovf);
    int unsigned lat;
    run8(a, b, sub, cin, lat);
    chk({tag, "_lat"}, lat, 8);
    chk({tag, "_done"}, {31'd0, o8_done}, 1);
    chk({tag, "_sum"}, {24'd0, o8_sum}, {24'd0, esum});
    chk({tag, "_cout"}, {31'd0, o8_cout}, {31'd0, ecout});
    chk({tag, "_ovf"}, {31'd0, o8_ovf}, {31'd0, eovf});
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_idle_busy"}, {31'd0, o8_busy}, 0);
    chk({tag, "_idle_done"}, {31'd0, o8_done}, 0);
  endtask

  initial begin
    int unsigned busy_cnt, done_cnt, lat;
    logic [7:0]  cap_sum;
    logic [4:0]  tot;
    logic [3:0]  esum4;
    logic        eovf4, stop4;

    checks = 0; failures = 0; last_ok = 1'b1;
    rst_n = 1'b0;
    s8_start = 1'b0; s8_sub = 1'b0; s8_cin = 1'b0; s8_a = '0; s8_b = '0;
    s4_start = 1'b0; s4_sub = 1'b0; s4_cin = 1'b0; s4_a = '0; s4_b = '0;

    // Reset and idle
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'd0, o8_busy}, 0);
    chk("rst_done", {31'd0, o8_done}, 0);
    chk("rst_sum", {24'd0, o8_sum}, 0);
    chk("rst_cout", {31'd0, o8_cout}, 0);
    chk("rst_ovf", {31'd0, o8_ovf}, 0);
    rst_n = 1'b1;
    done_cnt = 0;
    busy_cnt = 0;
    for (int unsigned i = 0; i < 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (o8_done) done_cnt++;
      if (o8_busy) busy_cnt++;
    end
    chk("idle_done_cnt", done_cnt, 0);
    chk("idle_busy_cnt", busy_cnt, 0);

    // Directed add/sub vectors
    vec8("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    vec8("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    vec8("add_00_00_c", 8'h00, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0);
    vec8("sub_05_07", 8'h05, 8'h07, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0);
    vec8("sub_80_01", 8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1);

    // Handshake: second start during RUN must be ignored
    s8_a = 8'h10; s8_b = 8'h20; s8_sub = 1'b0; s8_cin = 1'b0; s8_start = 1'b1;
    @(posedge clk);
    busy_cnt = 0; done_cnt = 0; cap_sum = 8'h00;
    for (int unsigned i = 0; i < 15; i++) begin
      @(negedge clk);
      s8_start = 1'b0;
      if (i == 2) begin
        s8_a = 8'hAA; s8_b = 8'h55; s8_sub = 1'b1; s8_start = 1'b1;
      end
      if (o8_busy) busy_cnt++;
      if (o8_done) begin
        done_cnt++;
        cap_sum = o8_sum;
      end
      @(posedge clk);
    end
    @(negedge clk);
    chk("hs_done_cnt", done_cnt, 1);
    chk("hs_busy_cnt", busy_cnt, 9);
    chk("hs_sum", {24'd0, cap_sum}, 32'h30);
    chk("hs_sum_hold", {24'd0, o8_sum}, 32'h30);
    chk("hs_busy_end", {31'd0, o8_busy}, 0);

    // Reset four cycles after accept
    s8_a = 8'h11; s8_b = 8'h22; s8_sub = 1'b0; s8_cin = 1'b0; s8_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s8_start = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mrst_busy", {31'd0, o8_busy}, 0);
    chk("mrst_done", {31'd0, o8_done}, 0);
    chk("mrst_sum", {24'd0, o8_sum}, 0);
    chk("mrst_cout", {31'd0, o8_cout}, 0);
    chk("mrst_ovf", {31'd0, o8_ovf}, 0);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int unsigned i = 0; i < 12; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (o8_done) done_cnt++;
    end
    chk("mrst_no_done", done_cnt, 0);
    vec8("post_rst_add", 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0);

    // Exhaustive WIDTH=4: mode 0 add cin=0, mode 1 add cin=1, mode 2 subtract
    stop4 = 1'b0;
    for (int unsigned m = 0; m < 3 && !stop4; m++) begin
      for (int unsigned ia = 0; ia < 16 && !stop4; ia++) begin
        for (int unsigned ib = 0; ib < 16 && !stop4; ib++) begin
          s4_a = 4'(ia); s4_b = 4'(ib);
          s4_sub = (m == 2); s4_cin = (m == 1); s4_start = 1'b1;
          @(posedge clk);
          @(negedge clk);
          s4_start = 1'b0;
          lat = 0;
          while (!o4_done && lat < 12) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
          end
          if (m == 2) begin
            tot   = 5'(ia) + 5'(4'(~ib)) + 5'd1;
            esum4 = tot[3:0];
            eovf4 = (s4_a[3] != s4_b[3]) && (esum4[3] != s4_a[3]);
          end else begin
            tot   = 5'(ia) + 5'(ib) + 5'(m);
            esum4 = tot[3:0];
            eovf4 = (s4_a[3] == s4_b[3]) && (esum4[3] != s4_a[3]);
          end
          chk($sformatf("w4 m=%0d a=%0h b=%0h lat/sum/cout/ovf", m, ia, ib),
              {16'(lat), 8'd0, o4_sum, o4_cout, o4_ovf, 2'd0},
              {16'd4, 8'd0, esum4, tot[4], eovf4, 2'd0});
          if (!last_ok) stop4 = 1'b1;
          @(posedge clk);
          @(negedge clk);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
